// File: rtl/vend_pkg.sv
// Shared types and codes for the vend/change dispense controller.
package vend_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StBotPulse,
        StBotWait,
        StCoinChk,
        StCoinPulse,
        StCoinWait,
        StFault
    } vend_state_e;

    localparam logic [1:0] CHG_NONE = 2'b00;
    localparam logic [1:0] CHG_5    = 2'b01;
    localparam logic [1:0] CHG_10   = 2'b10;

    localparam logic [1:0] FLT_NONE    = 2'b00;
    localparam logic [1:0] FLT_BOT_TO  = 2'b01;
    localparam logic [1:0] FLT_COIN_TO = 2'b10;
    localparam logic [1:0] FLT_EMPTY   = 2'b11;

    typedef struct packed {
        logic       bottle;
        logic [1:0] coins;
    } vend_req_t;

endpackage

// File: rtl/vend_req_fifo.sv
// Request queue; when full, a same-cycle pop frees the slot so the push is taken.
module vend_req_fifo
    import vend_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      push,
    input  vend_req_t push_data,
    input  logic      pop,
    output vend_req_t pop_data,
    output logic      push_ok,
    output logic      full,
    output logic      empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    vend_req_t     mem [DEPTH];
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic          do_pop;

    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop   = pop && !empty;
    assign push_ok  = push && (!full || do_pop);
    assign pop_data = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr[AW-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/vend_dispense_ctrl.sv
// Queues vend/change events and drives timed bottle/coin solenoid pulses confirmed by sensors.
// Define VEND_DISP_STATS_EN to add the bottles_served / coins_paid counters.
module vend_dispense_ctrl
    import vend_pkg::*;
#(
    parameter int unsigned PULSE_CYCLES   = 4,
    parameter int unsigned TIMEOUT_CYCLES = 64,
    parameter int unsigned FIFO_DEPTH     = 4,
    parameter int unsigned INV_W          = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             vend_out,
    input  logic [1:0]       vend_change,
    output logic             bottle_sol,
    input  logic             bottle_sense,
    output logic             coin_sol,
    input  logic             coin_sense,
    input  logic             inv_load,
    input  logic [INV_W-1:0] inv_value,
    output logic [INV_W-1:0] coin_count,
    output logic             busy,
    output logic             fifo_full,
    output logic             drop,
    output logic             fault,
    output logic [1:0]       fault_code
`ifdef VEND_DISP_STATS_EN
    ,
    output logic [15:0]      bottles_served,
    output logic [15:0]      coins_paid
`endif
);

    localparam int unsigned CntMax = (PULSE_CYCLES > TIMEOUT_CYCLES) ? PULSE_CYCLES
                                                                     : TIMEOUT_CYCLES;
    localparam int unsigned CntW   = $clog2(CntMax + 1);

    vend_state_e     state;
    logic [CntW-1:0] cnt;
    logic [1:0]      cur_coins;

    vend_req_t push_data;
    vend_req_t pop_data;
    logic      req_seen;
    logic      req_valid;
    logic      push;
    logic      push_ok;
    logic      pop;
    logic      empty;

    always_comb begin
        push_data.bottle = vend_out;
        unique case (vend_change)
            CHG_5:   push_data.coins = 2'd1;
            CHG_10:  push_data.coins = 2'd2;
            default: push_data.coins = 2'd0;
        endcase
    end

    // Code 11 alone carries nothing to dispense and is discarded.
    assign req_seen  = vend_out || (vend_change != CHG_NONE);
    assign req_valid = vend_out || (push_data.coins != 2'd0);
    assign push      = req_seen && req_valid && (state != StFault);
    assign pop       = (state == StIdle) && !empty;
    assign busy      = (state != StIdle) || !empty;

    vend_req_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .pop_data  (pop_data),
        .push_ok   (push_ok),
        .full      (fifo_full),
        .empty     (empty)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= StIdle;
            cnt        <= '0;
            cur_coins  <= 2'd0;
            bottle_sol <= 1'b0;
            coin_sol   <= 1'b0;
            coin_count <= '0;
            drop       <= 1'b0;
            fault      <= 1'b0;
            fault_code <= FLT_NONE;
`ifdef VEND_DISP_STATS_EN
            bottles_served <= 16'd0;
            coins_paid     <= 16'd0;
`endif
        end else begin
            drop <= req_seen && !push_ok;
            if (inv_load && (state == StIdle || state == StFault)) begin
                coin_count <= inv_value;
            end
            unique case (state)
                StIdle: begin
                    if (!empty) begin
                        cur_coins <= pop_data.coins;
                        if (pop_data.bottle) begin
                            state      <= StBotPulse;
                            bottle_sol <= 1'b1;
                            cnt        <= CntW'(PULSE_CYCLES - 1);
                        end else if (pop_data.coins != 2'd0) begin
                            state <= StCoinChk;
                        end
                    end
                end
                StBotPulse: begin
                    if (cnt == '0) begin
                        bottle_sol <= 1'b0;
                        state      <= StBotWait;
                    end else begin
                        cnt <= cnt - CntW'(1);
                    end
                end
                StBotWait: begin
                    if (bottle_sense) begin
                        state <= (cur_coins != 2'd0) ? StCoinChk : StIdle;
`ifdef VEND_DISP_STATS_EN
                        if (bottles_served != 16'hFFFF) bottles_served <= bottles_served + 16'd1;
`endif
                    end else if (cnt == CntW'(TIMEOUT_CYCLES - 1)) begin
                        state      <= StFault;
                        fault      <= 1'b1;
                        fault_code <= FLT_BOT_TO;
                    end else begin
                        cnt <= cnt + CntW'(1);
                    end
                end
                StCoinChk: begin
                    if (coin_count == '0) begin
                        state      <= StFault;
                        fault      <= 1'b1;
                        fault_code <= FLT_EMPTY;
                    end else begin
                        state    <= StCoinPulse;
                        coin_sol <= 1'b1;
                        cnt      <= CntW'(PULSE_CYCLES - 1);
                    end
                end
                StCoinPulse: begin
                    if (cnt == '0) begin
                        coin_sol <= 1'b0;
                        state    <= StCoinWait;
                    end else begin
                        cnt <= cnt - CntW'(1);
                    end
                end
                StCoinWait: begin
                    if (coin_sense) begin
                        if (coin_count != '0) coin_count <= coin_count - INV_W'(1);
                        cur_coins <= cur_coins - 2'd1;
                        state     <= (cur_coins == 2'd1) ? StIdle : StCoinChk;
`ifdef VEND_DISP_STATS_EN
                        if (coins_paid != 16'hFFFF) coins_paid <= coins_paid + 16'd1;
`endif
                    end else if (cnt == CntW'(TIMEOUT_CYCLES - 1)) begin
                        state      <= StFault;
                        fault      <= 1'b1;
                        fault_code <= FLT_COIN_TO;
                    end else begin
                        cnt <= cnt + CntW'(1);
                    end
                end
                StFault: begin
                    bottle_sol <= 1'b0;
                    coin_sol   <= 1'b0;
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_vend_dispense_ctrl.sv
// Scenario bench for vend_dispense_ctrl with an auto-echo sensor model and a transaction-level
// reference for randomized requests.
module tb_vend_dispense_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       vend_out;
    logic [1:0] vend_change;
    logic       bottle_sol;
    logic       bottle_sense;
    logic       coin_sol;
    logic       coin_sense;
    logic       inv_load;
    logic [7:0] inv_value;
    logic [7:0] coin_count;
    logic       busy;
    logic       fifo_full;
    logic       drop;
    logic       fault;
    logic [1:0] fault_code;
`ifdef VEND_DISP_STATS_EN
    logic [15:0] bottles_served;
    logic [15:0] coins_paid;
`endif

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    // Sensor model controls (written by the main thread only).
    bit echo_b = 1'b1;
    bit echo_c = 1'b1;
    bit man_bsense = 1'b0;

    // Monitor state (written by the monitor only).
    int bot_w[$];
    int coin_w[$];
    int b_run = 0, c_run = 0, drop_cnt = 0, b_fall_cyc = 0, fault_cyc = 0;
    bit fault_prev = 1'b0;

    // Responder state.
    int b_dly = 0, c_dly = 0;
    bit prev_b = 1'b0, prev_c = 1'b0;

    vend_dispense_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .vend_out     (vend_out),
        .vend_change  (vend_change),
        .bottle_sol   (bottle_sol),
        .bottle_sense (bottle_sense),
        .coin_sol     (coin_sol),
        .coin_sense   (coin_sense),
        .inv_load     (inv_load),
        .inv_value    (inv_value),
        .coin_count   (coin_count),
        .busy         (busy),
        .fifo_full    (fifo_full),
        .drop         (drop),
        .fault        (fault),
        .fault_code   (fault_code)
`ifdef VEND_DISP_STATS_EN
        ,
        .bottles_served (bottles_served),
        .coins_paid     (coins_paid)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Sensors echo two cycles after each solenoid pulse ends.
    initial begin
        bottle_sense = 1'b0;
        coin_sense   = 1'b0;
        forever begin
            @(negedge clk);
            bottle_sense = man_bsense;
            coin_sense   = 1'b0;
            if (b_dly != 0) begin b_dly--; if (b_dly == 0) bottle_sense = 1'b1; end
            if (c_dly != 0) begin c_dly--; if (c_dly == 0) coin_sense = 1'b1; end
            if (prev_b && !bottle_sol && echo_b) b_dly = 2;
            if (prev_c && !coin_sol && echo_c) c_dly = 2;
            prev_b = bottle_sol;
            prev_c = coin_sol;
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (bottle_sol === 1'b1) b_run++;
            else if (b_run != 0) begin bot_w.push_back(b_run); b_run = 0; b_fall_cyc = cyc; end
            if (coin_sol === 1'b1) c_run++;
            else if (c_run != 0) begin coin_w.push_back(c_run); c_run = 0; end
            if (drop === 1'b1) drop_cnt++;
            if (fault === 1'b1 && !fault_prev) fault_cyc = cyc;
            fault_prev = (fault === 1'b1);
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        step();
        step();
        rst = 1'b1;
        step();
    endtask

    task automatic load(input logic [7:0] v);
        inv_load  = 1'b1;
        inv_value = v;
        step();
        inv_load  = 1'b0;
    endtask

    task automatic issue(input logic v, input logic [1:0] c);
        vend_out    = v;
        vend_change = c;
        step();
        vend_out    = 1'b0;
        vend_change = 2'b00;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (busy && !fault && n < 400) begin step(); n++; end
        checks++;
        if (busy && !fault) begin
            errors++;
            $display("FAIL %s_idle_timeout: busy=%0b after %0d cycles, want 0", name, busy, n);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        step();
        step();
        checks++;
        if ({bottle_sol, coin_sol, drop, fault} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_outs: sol/sol/drop/fault=%b want 0000",
                     {bottle_sol, coin_sol, drop, fault});
        end
        checks++;
        if (fault_code !== 2'b00 || coin_count !== 8'd0) begin
            errors++;
            $display("FAIL reset_regs: code=%0d count=%0d want 0 0", fault_code, coin_count);
        end
        checks++;
        if (busy !== 1'b0 || fifo_full !== 1'b0) begin
            errors++;
            $display("FAIL reset_busy: busy=%0b full=%0b want 0 0", busy, fifo_full);
        end
        rst = 1'b1;
        step();
    endtask

    task automatic test_basic();
        int b0, c0;
        do_reset();
        load(8'd3);
        b0 = bot_w.size();
        c0 = coin_w.size();
        issue(1'b1, 2'b01);
        checks++;
        if (bottle_sol !== 1'b0) begin
            errors++;
            $display("FAIL basic_lat1: bottle_sol=%0b want 0 one cycle after push", bottle_sol);
        end
        step();
        checks++;
        if (bottle_sol !== 1'b1) begin
            errors++;
            $display("FAIL basic_lat2: bottle_sol=%0b want 1 two cycles after push", bottle_sol);
        end
        load(8'd9);  // mid-pulse load must be ignored
        wait_idle("basic");
        step();
        checks++;
        if (bot_w.size() - b0 != 1 || coin_w.size() - c0 != 1) begin
            errors++;
            $display("FAIL basic_pulses: bottle=%0d coin=%0d want 1 1",
                     bot_w.size() - b0, coin_w.size() - c0);
        end else begin
            checks++;
            if (bot_w[b0] != 4 || coin_w[c0] != 4) begin
                errors++;
                $display("FAIL basic_width: bottle=%0d coin=%0d want 4 4", bot_w[b0], coin_w[c0]);
            end
        end
        checks++;
        if (coin_count !== 8'd2 || busy !== 1'b0 || fault !== 1'b0) begin
            errors++;
            $display("FAIL basic_end: count=%0d busy=%0b fault=%0b want 2 0 0",
                     coin_count, busy, fault);
        end
    endtask

    task automatic test_hopper_empty();
        int c0, b0, d0;
        do_reset();
        load(8'd1);
        c0 = coin_w.size();
        issue(1'b0, 2'b10);
        wait_idle("hopper");
        step();
        checks++;
        if (fault !== 1'b1 || fault_code !== 2'b11) begin
            errors++;
            $display("FAIL hopper_fault: fault=%0b code=%0d want 1 3", fault, fault_code);
        end
        checks++;
        if (coin_count !== 8'd0 || coin_w.size() - c0 != 1) begin
            errors++;
            $display("FAIL hopper_coin: count=%0d pulses=%0d want 0 1",
                     coin_count, coin_w.size() - c0);
        end
        b0 = bot_w.size();
        c0 = coin_w.size();
        d0 = drop_cnt;
        issue(1'b1, 2'b00);
        issue(1'b0, 2'b01);
        repeat (12) step();
        checks++;
        if (drop_cnt - d0 != 2 || bot_w.size() != b0 || coin_w.size() != c0) begin
            errors++;
            $display("FAIL hopper_drop: drops=%0d pulses=%0d/%0d want 2 0/0",
                     drop_cnt - d0, bot_w.size() - b0, coin_w.size() - c0);
        end
        load(8'd7);
        checks++;
        if (coin_count !== 8'd7) begin
            errors++;
            $display("FAIL hopper_fault_load: count=%0d want 7", coin_count);
        end
    endtask

    task automatic test_bottle_timeout();
        int n = 0;
        int b0;
        rst = 1'b0;
        step();
        step();
        checks++;
        if (fault !== 1'b0 || fault_code !== 2'b00) begin
            errors++;
            $display("FAIL fault_clear: fault=%0b code=%0d want 0 0", fault, fault_code);
        end
        rst = 1'b1;
        step();
        echo_b = 1'b0;
        b0 = bot_w.size();
        issue(1'b1, 2'b00);
        while (!fault && n < 200) begin step(); n++; end
        repeat (5) step();
        checks++;
        if (fault !== 1'b1 || fault_code !== 2'b01) begin
            errors++;
            $display("FAIL bto_code: fault=%0b code=%0d want 1 1", fault, fault_code);
        end
        checks++;
        if (fault_cyc - b_fall_cyc != 64) begin
            errors++;
            $display("FAIL bto_delay: %0d cycles after fall, want 64", fault_cyc - b_fall_cyc);
        end
        checks++;
        if (bottle_sol !== 1'b0 || bot_w.size() - b0 != 1) begin
            errors++;
            $display("FAIL bto_sol: bottle_sol=%0b pulses=%0d want 0 1",
                     bottle_sol, bot_w.size() - b0);
        end
        echo_b = 1'b1;
    endtask

    task automatic test_back_to_back();
        int n = 0;
        int b0, d0;
        do_reset();
        echo_b = 1'b0;
        b0 = bot_w.size();
        d0 = drop_cnt;
        issue(1'b1, 2'b00);
        while (!bottle_sol && n < 10) begin step(); n++; end
        for (int i = 0; i < 5; i++) issue(1'b1, 2'b00);
        step();
        checks++;
        if (fifo_full !== 1'b1 || drop_cnt - d0 != 1) begin
            errors++;
            $display("FAIL stall_full: full=%0b drops=%0d want 1 1", fifo_full, drop_cnt - d0);
        end
        // Confirm the first bottle by hand so the push lands on the IDLE pop edge.
        man_bsense = 1'b1;
        step();
        man_bsense = 1'b0;
        step();
        issue(1'b1, 2'b00);
        checks++;
        if (fifo_full !== 1'b1 || drop_cnt - d0 != 1) begin
            errors++;
            $display("FAIL stall_pop_push: full=%0b drops=%0d want 1 1", fifo_full, drop_cnt - d0);
        end
        echo_b = 1'b1;
        wait_idle("stall");
        step();
        checks++;
        if (bot_w.size() - b0 != 6 || fifo_full !== 1'b0 || fault !== 1'b0) begin
            errors++;
            $display("FAIL stall_served: bottles=%0d full=%0b fault=%0b want 6 0 0",
                     bot_w.size() - b0, fifo_full, fault);
        end
    endtask

    task automatic test_reset_mid_pulse();
        int n = 0;
        int c0;
        do_reset();
        load(8'd5);
        issue(1'b0, 2'b01);
        while (!coin_sol && n < 20) begin step(); n++; end
        step();
        rst = 1'b0;
        step();
        checks++;
        if (coin_sol !== 1'b0 || coin_count !== 8'd0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL midrst: coin_sol=%0b count=%0d busy=%0b want 0 0 0",
                     coin_sol, coin_count, busy);
        end
        rst = 1'b1;
        repeat (4) step();
        load(8'd2);
        c0 = coin_w.size();
        issue(1'b0, 2'b01);
        wait_idle("midrst");
        step();
        checks++;
        if (coin_count !== 8'd1 || coin_w.size() - c0 != 1 || fault !== 1'b0) begin
            errors++;
            $display("FAIL midrst_after: count=%0d pulses=%0d fault=%0b want 1 1 0",
                     coin_count, coin_w.size() - c0, fault);
        end
    endtask

    task automatic test_random();
        int inv, nc, eb, ec, ed, ecode, b0, c0, d0;
        logic v;
        logic [1:0] c;
        do_reset();
        inv = 0;
        for (int i = 0; i < 24; i++) begin
            if ($urandom_range(1, 0) == 1) begin
                inv = int'($urandom_range(4, 0));
                load(8'(inv));
            end
            v = 1'($urandom_range(1, 0));
            c = 2'($urandom_range(3, 0));
            if (!v && c == 2'b00) c = 2'b01;
            nc = (c == 2'b01) ? 1 : (c == 2'b10) ? 2 : 0;
            eb = v ? 1 : 0;
            ed = (!v && c == 2'b11) ? 1 : 0;
            ecode = 0;
            if (nc > inv) begin ec = inv; inv = 0; ecode = 3; end
            else begin ec = nc; inv = inv - nc; end
            b0 = bot_w.size();
            c0 = coin_w.size();
            d0 = drop_cnt;
            issue(v, c);
            wait_idle("rand");
            repeat (3) step();
            checks++;
            if (bot_w.size() - b0 != eb || coin_w.size() - c0 != ec || drop_cnt - d0 != ed) begin
                errors++;
                $display("FAIL rand%0d_pulses: b/c/drop=%0d/%0d/%0d want %0d/%0d/%0d", i,
                         bot_w.size() - b0, coin_w.size() - c0, drop_cnt - d0, eb, ec, ed);
            end
            checks++;
            if (coin_count !== 8'(inv) || fault_code !== 2'(ecode) || fault !== (ecode != 0)) begin
                errors++;
                $display("FAIL rand%0d_state: count=%0d code=%0d fault=%0b want %0d %0d %0b", i,
                         coin_count, fault_code, fault, inv, ecode, ecode != 0);
            end
            for (int k = c0; k < coin_w.size(); k++) begin
                checks++;
                if (coin_w[k] != 4) begin
                    errors++;
                    $display("FAIL rand%0d_cwidth: %0d want 4", i, coin_w[k]);
                end
            end
            if (ecode != 0) begin
                do_reset();
                inv = 0;
            end
        end
    endtask

`ifdef VEND_DISP_STATS_EN
    task automatic test_stats();
        do_reset();
        load(8'd10);
        for (int i = 0; i < 3; i++) begin
            issue(1'b1, 2'b01);
            wait_idle("stats");
        end
        step();
        checks++;
        if (bottles_served !== 16'd3 || coins_paid !== 16'd3) begin
            errors++;
            $display("FAIL stats: bottles=%0d coins=%0d want 3 3", bottles_served, coins_paid);
        end
    endtask
`endif

    initial begin
        rst         = 1'b0;
        vend_out    = 1'b0;
        vend_change = 2'b00;
        inv_load    = 1'b0;
        inv_value   = 8'd0;
        test_reset();
        test_basic();
        test_hopper_empty();
        test_bottle_timeout();
        test_back_to_back();
        test_reset_mid_pulse();
        test_random();
`ifdef VEND_DISP_STATS_EN
        test_stats();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
